fu_ctrl: RTL

//  Issue side of the function-unit interface. Accepts one instruction per valid/ready handshake.

---
 rtl/mycpu_pkg.sv | 61 ++++++
 rtl/fu_ctrl_if.sv | 29 ++
 rtl/fu_regfile.sv | 43 ++++
 rtl/fu_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared datapath types for the mycpu issue path: instruction layout, opcodes,
// function-unit select codes and the fu_ctrl FSM states.
package mycpu_pkg;

    localparam int unsigned DW    = 16;
    localparam int unsigned NREGS = 8;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_MOV = 4'h7
    } opcode_t;

    typedef enum logic [2:0] {
        FS_NOP,
        FS_ADD,
        FS_SUB,
        FS_AND,
        FS_OR,
        FS_XOR,
        FS_NOT,
        FS_PASSA
    } fs_t;

    typedef struct packed {
        opcode_t  op;
        reg_idx_t rd;
        reg_idx_t ra;
        reg_idx_t rb;
        reg_idx_t rsvd;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } fu_ctrl_state_t;

    // Opcodes without a function-unit mapping still complete, driving FS_NOP.
    function automatic fs_t op2fs(input opcode_t op);
        case (op)
            OP_ADD:  return FS_ADD;
            OP_SUB:  return FS_SUB;
            OP_AND:  return FS_AND;
            OP_OR:   return FS_OR;
            OP_XOR:  return FS_XOR;
            OP_NOT:  return FS_NOT;
            OP_MOV:  return FS_PASSA;
            default: return FS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/fu_ctrl_if.sv
// Instruction handshake, fu operand/result and write-back bundle of fu_ctrl.
// slave = fu_ctrl side, master = fetch/decode plus fu side.
interface fu_ctrl_if;
    import mycpu_pkg::*;

    logic [DW-1:0] instr_in;
    logic          instr_vld;
    logic          instr_rdy;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    fs_t           fs_out;
    logic [DW-1:0] f_in;
    logic [1:0]    nz_in;
    logic [1:0]    nz_q;
    logic          wb_vld;
    logic [DW-1:0] wb_data;
    logic          busy;

    modport slave (
        input  instr_in, instr_vld, f_in, nz_in,
        output instr_rdy, a_out, b_out, fs_out, nz_q, wb_vld, wb_data, busy
    );

    modport master (
        output instr_in, instr_vld, f_in, nz_in,
        input  instr_rdy, a_out, b_out, fs_out, nz_q, wb_vld, wb_data, busy
    );

endinterface

// File: rtl/fu_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write port.
// FU_CTRL_ZERO_R0_EN hardwires R0 to zero.
module fu_regfile
    import mycpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  reg_idx_t      ra_a_i,
    input  reg_idx_t      ra_b_i,
    output logic [DW-1:0] rd_a_o,
    output logic [DW-1:0] rd_b_o,
    input  logic          we_i,
    input  reg_idx_t      wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
`ifdef FU_CTRL_ZERO_R0_EN
            if (wa_i != '0) begin
                regs_q[wa_i] <= wd_i;
            end
`else
            regs_q[wa_i] <= wd_i;
`endif
        end
    end

`ifdef FU_CTRL_ZERO_R0_EN
    assign rd_a_o = (ra_a_i == '0) ? '0 : regs_q[ra_a_i];
    assign rd_b_o = (ra_b_i == '0) ? '0 : regs_q[ra_b_i];
`else
    assign rd_a_o = regs_q[ra_a_i];
    assign rd_b_o = regs_q[ra_b_i];
`endif

endmodule

// File: rtl/fu_ctrl.sv
// Issue controller for fu: accept, read operands, wait FU_LAT cycles, write back.
// Optional build macro: FU_CTRL_ZERO_R0_EN (R0 hardwired to zero, handled in fu_regfile).
module fu_ctrl
    import mycpu_pkg::*;
#(
    parameter int unsigned FU_LAT = 1
) (
    input logic     clk,
    input logic     rst_n,
    fu_ctrl_if.slave bus
);

    localparam logic [2:0] CNT_INIT = 3'(FU_LAT - 1);

    fu_ctrl_state_t state_q;
    instr_t         instr_q;
    logic [2:0]     cnt_q;
    logic [DW-1:0]  a_q, b_q, f_q, wbd_q;
    fs_t            fs_q;
    logic [1:0]     nzc_q, stat_q;
    logic           wbv_q;
    logic [DW-1:0]  rd_a, rd_b;
    logic           unused_rsvd;

    fu_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra_a_i (instr_q.ra),
        .ra_b_i (instr_q.rb),
        .rd_a_o (rd_a),
        .rd_b_o (rd_b),
        .we_i   (state_q == WB),
        .wa_i   (instr_q.rd),
        .wd_i   (f_q)
    );

    // The write-back pulse and status update land on the edge leaving WB,
    // together with the register-file write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fs_q    <= FS_NOP;
            f_q     <= '0;
            nzc_q   <= '0;
            stat_q  <= '0;
            wbv_q   <= 1'b0;
            wbd_q   <= '0;
        end else begin
            wbv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_vld) begin
                        instr_q <= instr_t'(bus.instr_in);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    a_q     <= rd_a;
                    b_q     <= rd_b;
                    fs_q    <= op2fs(instr_q.op);
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        f_q     <= bus.f_in;
                        nzc_q   <= bus.nz_in;
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WB: begin
                    stat_q  <= nzc_q;
                    wbv_q   <= 1'b1;
                    wbd_q   <= f_q;
                    fs_q    <= FS_NOP;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_rdy = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.fs_out    = fs_q;
    assign bus.nz_q      = stat_q;
    assign bus.wb_vld    = wbv_q;
    assign bus.wb_data   = wbd_q;
    assign unused_rsvd   = ^instr_q.rsvd;

endmodule
